// File: rtl/mips_pkg.sv
// Shared register-file write-port types for the MIPS pipeline.
// Holds the address and data widths, the hard-wired zero register and the
// {addr, data} write request that the WB stage and the long-latency unit use.
package mips_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;

   localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]     data;
   } wb_req_t;

   // A write to $0 changes nothing, so it does not occupy the write port.
   function automatic logic is_live_write(input logic                  we,
                                          input logic [REG_ADDR_W-1:0] addr);
      return we && (addr != ZERO_REG);
   endfunction

endpackage

// File: rtl/wb_arb_fifo.sv
// Synchronous FIFO of wb_req_t used to buffer long-latency unit results.
// Occupancy is tracked with a counter; empty/full are registered from the
// next-state count so they change only at clock edges. The head entry is
// read combinationally so the arbiter can drive it onto the write port in
// the same cycle it is granted. Push while full and pop while empty are ignored.
module wb_arb_fifo
   import mips_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic    Clk,
   input  logic    Rst_n,
   input  logic    push,
   input  logic    pop,
   input  wb_req_t din,
   output wb_req_t dout,
   output logic    empty,
   output logic    full
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   wb_req_t          mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;
   logic             empty_reg;
   logic             full_reg;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full_reg;
   assign do_pop  = pop && !empty_reg;

   // Next occupancy from the accepted push/pop pair.
   always_comb begin
      count_next = count_reg;
      case ({do_push, do_pop})
         2'b10:   count_next = count_reg + CNT_ONE;
         2'b01:   count_next = count_reg - CNT_ONE;
         default: count_next = count_reg;
      endcase
   end

   // Entry storage; contents need no reset because occupancy gates every read.
   always_ff @(posedge Clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   // Read/write pointers wrap explicitly at the last entry.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
         end
      end
   end

   // Occupancy counter plus registered empty/full flags derived from it.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         count_reg <= '0;
         empty_reg <= 1'b1;
         full_reg  <= 1'b0;
      end else begin
         count_reg <= count_next;
         empty_reg <= (count_next == '0);
         full_reg  <= (count_next == CNT_FULL);
      end
   end

   assign dout  = mem[rd_ptr_reg];
   assign empty = empty_reg;
   assign full  = full_reg;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the WB stage and buffered
// long-latency (mult/div) results. WB has priority; LL results wait in a
// small FIFO and take idle WB slots (no WB write, or a WB write to $0).
// Optional macro WB_ARB_STARVE_GUARD_EN adds a starvation counter that
// raises Pipe_Stall for one cycle so a long-denied LL result is written
// while the held MEM/WB register re-presents its write on the next cycle.
// Without the macro Pipe_Stall is tied low and LL_Ready is the only
// back-pressure to the LL unit.
module wb_port_arbiter
   import mips_pkg::*;
#(
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   input  logic                  RegWrite_WB,
   input  logic [REG_ADDR_W-1:0] Write_Register_WB,
   input  logic [DATA_W-1:0]     Write_Data_WB,
   input  logic                  LL_Valid,
   output logic                  LL_Ready,
   input  logic [REG_ADDR_W-1:0] LL_Register,
   input  logic [DATA_W-1:0]     LL_Data,
   output logic                  RF_WriteEn,
   output logic [REG_ADDR_W-1:0] RF_WriteAddr,
   output logic [DATA_W-1:0]     RF_WriteData,
   output logic                  Pipe_Stall
);

   logic    wb_eff;
   logic    grant_ll;
   logic    fifo_push;
   logic    fifo_empty;
   logic    fifo_full;
   wb_req_t fifo_din;
   wb_req_t fifo_head;

   assign wb_eff = is_live_write(RegWrite_WB, Write_Register_WB);

   // LL_Ready is the inverse of the FIFO's registered full flag, so it only
   // moves at clock edges. A pop from a full FIFO does not reopen it until
   // the next cycle.
   assign LL_Ready  = !fifo_full;
   assign fifo_push = LL_Valid && LL_Ready;
   assign fifo_din  = '{addr: LL_Register, data: LL_Data};

   wb_arb_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .push  (fifo_push),
      .pop   (grant_ll),
      .din   (fifo_din),
      .dout  (fifo_head),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

`ifdef WB_ARB_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(STARVE_LIMIT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt_reg;
   logic             pipe_stall_reg;
   logic             head_denied;

   // During a stall cycle WB is suppressed, so a waiting head always wins.
   assign grant_ll    = !fifo_empty && (pipe_stall_reg || !wb_eff);
   assign head_denied = !fifo_empty && !grant_ll;

   // Count consecutive denials of the FIFO head and request a single-cycle
   // stall once the head has been denied at the trip count.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         starve_cnt_reg <= '0;
         pipe_stall_reg <= 1'b0;
      end else begin
         if (!head_denied) begin
            starve_cnt_reg <= '0;
         end else if (starve_cnt_reg != CNT_MAX) begin
            starve_cnt_reg <= starve_cnt_reg + CNT_W'(1);
         end
         pipe_stall_reg <= !pipe_stall_reg && head_denied &&
                           (starve_cnt_reg == CNT_TRIP);
      end
   end

   assign Pipe_Stall = pipe_stall_reg;
`else
   // Without the guard LL results drain only through free WB slots.
   assign grant_ll   = !fifo_empty && !wb_eff;
   assign Pipe_Stall = 1'b0;
`endif

   // Write-port mux: granted FIFO head, otherwise WB pass-through. A granted
   // $0 head is popped but not written. WB is suppressed while stalled and
   // everything is quiet while reset is asserted.
   always_comb begin
      RF_WriteAddr = Write_Register_WB;
      RF_WriteData = Write_Data_WB;
      RF_WriteEn   = wb_eff && !Pipe_Stall;
      if (grant_ll) begin
         RF_WriteAddr = fifo_head.addr;
         RF_WriteData = fifo_head.data;
         RF_WriteEn   = (fifo_head.addr != ZERO_REG);
      end
      if (!Rst_n) begin
         RF_WriteEn = 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter. A queue-based reference model
// tracks buffered LL results and consecutive head denials; directed and
// random scenarios compare the full output vector every cycle.
module tb_wb_port_arbiter;

   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        RegWrite_WB;
   logic [4:0]  Write_Register_WB;
   logic [31:0] Write_Data_WB;
   logic        LL_Valid;
   logic        LL_Ready;
   logic [4:0]  LL_Register;
   logic [31:0] LL_Data;
   logic        RF_WriteEn;
   logic [4:0]  RF_WriteAddr;
   logic [31:0] RF_WriteData;
   logic        Pipe_Stall;

   always #5 Clk = ~Clk;

   wb_port_arbiter #(
      .FIFO_DEPTH   (DEPTH),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .Clk               (Clk),
      .Rst_n             (Rst_n),
      .RegWrite_WB       (RegWrite_WB),
      .Write_Register_WB (Write_Register_WB),
      .Write_Data_WB     (Write_Data_WB),
      .LL_Valid          (LL_Valid),
      .LL_Ready          (LL_Ready),
      .LL_Register       (LL_Register),
      .LL_Data           (LL_Data),
      .RF_WriteEn        (RF_WriteEn),
      .RF_WriteAddr      (RF_WriteAddr),
      .RF_WriteData      (RF_WriteData),
      .Pipe_Stall        (Pipe_Stall)
   );

   // observed vector: {en, addr[4:0], data[31:0], ready, stall}
   logic [39:0] obs;
   assign obs = {RF_WriteEn, RF_WriteAddr, RF_WriteData, LL_Ready, Pipe_Stall};

   typedef struct packed {
      logic [4:0]  r;
      logic [31:0] d;
   } ent_t;

   ent_t        q[$];
   logic        m_stall;
   int          m_denied;
   logic        m_grant;
   logic [39:0] exp_vec;
   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;

   task automatic model_reset;
      q.delete();
      m_stall  = 1'b0;
      m_denied = 0;
      m_grant  = 1'b0;
   endtask

   // Expected outputs for the current cycle from the model state and inputs.
   task automatic model_eval;
      logic        wb_eff;
      logic        en;
      logic        rdy;
      logic [4:0]  a;
      logic [31:0] d;
      wb_eff  = RegWrite_WB && (Write_Register_WB != 5'd0);
      m_grant = Rst_n && (q.size() > 0) && (m_stall || !wb_eff);
      a  = Write_Register_WB;
      d  = Write_Data_WB;
      en = wb_eff && !m_stall;
      if (m_grant) begin
         a  = q[0].r;
         d  = q[0].d;
         en = (q[0].r != 5'd0);
      end
      if (!Rst_n) en = 1'b0;
      rdy = (q.size() < DEPTH);
      exp_vec = {en, a, d, rdy, m_stall};
   endtask

   // Advance the model across one clock edge.
   task automatic model_commit;
      logic push;
      logic new_stall;
      if (!Rst_n) begin
         model_reset();
         return;
      end
      push      = LL_Valid && (q.size() < DEPTH);
      new_stall = 1'b0;
`ifdef WB_ARB_STARVE_GUARD_EN
      if ((q.size() > 0) && !m_grant) begin
         m_denied++;
         if ((m_denied == LIMIT) && !m_stall) new_stall = 1'b1;
      end else begin
         m_denied = 0;
      end
`endif
      if (m_grant) void'(q.pop_front());
      if (push) q.push_back({LL_Register, LL_Data});
      m_stall = new_stall;
   endtask

   task automatic drive(input logic rw, input logic [4:0] wr, input logic [31:0] wd,
                        input logic lv, input logic [4:0] lr, input logic [31:0] ld);
      RegWrite_WB       = rw;
      Write_Register_WB = wr;
      Write_Data_WB     = wd;
      LL_Valid          = lv;
      LL_Register       = lr;
      LL_Data           = ld;
      @(negedge Clk);
      model_eval();
      $display("cyc %0d: wb=%b r%0d ll=%b r%0d -> rf_en=%b r%0d data=%h ready=%b stall=%b",
               cyc, rw, wr, lv, lr, RF_WriteEn, RF_WriteAddr, RF_WriteData, LL_Ready, Pipe_Stall);
   endtask

   task automatic tick;
      @(posedge Clk);
      model_commit();
      #1;
      cyc++;
   endtask

   task automatic test_reset;
      Rst_n = 1'b0;
      model_reset();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66);
         n_vec++;
         if (obs !== exp_vec) begin
            n_err++;
            $display("FAIL reset cyc=%0d actual=%h required=%h", cyc, obs, exp_vec);
         end
         n_vec++;
         if ({RF_WriteEn, LL_Ready, Pipe_Stall} !== 3'b010) begin
            n_err++;
            $display("FAIL reset_flags cyc=%0d actual=%b required=010", cyc,
                     {RF_WriteEn, LL_Ready, Pipe_Stall});
         end
         tick();
      end
      Rst_n = 1'b1;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
         n_vec++;
         if (obs !== exp_vec) begin
            n_err++;
            $display("FAIL %s_drain cyc=%0d actual=%h required=%h", tag, cyc, obs, exp_vec);
         end
         tick();
      end
   endtask

   task automatic test_idle_slot;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 5'd0, 32'h0, i == 0, 5'd8, 32'hDEADBEEF);
         n_vec++;
         if (obs !== exp_vec) begin
            n_err++;
            $display("FAIL idle cyc=%0d actual=%h required=%h", cyc, obs, exp_vec);
         end
         if (i == 1) begin
            n_vec++;
            if ({RF_WriteEn, RF_WriteAddr, RF_WriteData} !== {1'b1, 5'd8, 32'hDEADBEEF}) begin
               n_err++;
               $display("FAIL idle_write cyc=%0d actual=%b/%0d/%h required=1/8/deadbeef",
                        cyc, RF_WriteEn, RF_WriteAddr, RF_WriteData);
            end
         end
         tick();
      end
   endtask

   task automatic test_starvation;
      int stalls   = 0;
      int stall_at = -1;
      int prio_ok  = 0;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 5'd3, 32'h11, i == 0, 5'd9, 32'h0000A5A5);
         n_vec++;
         if (obs !== exp_vec) begin
            n_err++;
            $display("FAIL starve cyc=%0d actual=%h required=%h", cyc, obs, exp_vec);
         end
         if (Pipe_Stall === 1'b1) begin
            stalls++;
            if (stall_at < 0) stall_at = i;
         end else if (stall_at < 0 && RF_WriteAddr === 5'd3 && RF_WriteData === 32'h11) begin
            prio_ok++;
         end
         tick();
      end
`ifdef WB_ARB_STARVE_GUARD_EN
      n_vec++;
      if (stalls !== 1 || stall_at !== 5 || prio_ok !== 5) begin
         n_err++;
         $display("FAIL starve_stall actual=%0d stalls at %0d prio %0d required=1 stalls at 5 prio 5",
                  stalls, stall_at, prio_ok);
      end
`else
      n_vec++;
      if (stalls !== 0 || prio_ok !== 10) begin
         n_err++;
         $display("FAIL starve_nostall actual=%0d stalls prio %0d required=0 stalls prio 10",
                  stalls, prio_ok);
      end
`endif
      drain("starve");
   endtask

   task automatic test_full;
      logic [4:0] regs [3];
      int         idx = 0;
      regs[0] = 5'd10;
      regs[1] = 5'd11;
      regs[2] = 5'd12;
      for (int i = 0; i < 9; i++) begin
         drive(i < 4, 5'd3, 32'h11, idx < 3, regs[idx % 3], 32'h100 + idx);
         n_vec++;
         if (obs !== exp_vec) begin
            n_err++;
            $display("FAIL full cyc=%0d actual=%h required=%h", cyc, obs, exp_vec);
         end
         if (i == 2 || i == 4 || i == 5) begin
            n_vec++;
            if (LL_Ready !== (i == 5)) begin
               n_err++;
               $display("FAIL full_ready step=%0d actual=%b required=%b", i, LL_Ready, i == 5);
            end
         end
         if (idx < 3 && exp_vec[1]) idx++;
         tick();
      end
      drain("full");
   endtask

   task automatic test_zero;
      for (int i = 0; i < 5; i++) begin
         drive(i < 4, (i < 2) ? 5'd3 : 5'd0, 32'h11, i < 2,
               (i == 0) ? 5'd0 : 5'd7, (i == 0) ? 32'd5 : 32'h77);
         n_vec++;
         if (obs !== exp_vec) begin
            n_err++;
            $display("FAIL zero cyc=%0d actual=%h required=%h", cyc, obs, exp_vec);
         end
         if (i == 2 || i == 3) begin
            n_vec++;
            if ({RF_WriteEn, RF_WriteAddr} !== ((i == 2) ? {1'b0, 5'd0} : {1'b1, 5'd7})) begin
               n_err++;
               $display("FAIL zero_slot step=%0d actual=%b/%0d required=%0d", i,
                        RF_WriteEn, RF_WriteAddr, (i == 2) ? 0 : 7);
            end
         end
         tick();
      end
      drain("zero");
   endtask

   task automatic test_random;
      logic [4:0] wr;
      logic [4:0] lr;
      for (int i = 0; i < 300; i++) begin
         wr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         lr = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         drive(1'($urandom_range(0, 99) < 60), wr, $urandom, 1'($urandom_range(0, 1)), lr, $urandom);
         n_vec++;
         if (obs !== exp_vec) begin
            n_err++;
            $display("FAIL random cyc=%0d actual=%h required=%h", cyc, obs, exp_vec);
         end
         tick();
      end
      drain("random");
   endtask

   task automatic test_reset_mid;
      int stale = 0;
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 5'd3, 32'h11, 1'b1, 5'(20 + i), 32'hBAD0 + i);
         n_vec++;
         if (obs !== exp_vec) begin
            n_err++;
            $display("FAIL rstmid_fill cyc=%0d actual=%h required=%h", cyc, obs, exp_vec);
         end
         tick();
      end
      Rst_n = 1'b0;
      model_reset();
      drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd22, 32'hBAD2);
      n_vec++;
      if ({RF_WriteEn, LL_Ready, Pipe_Stall} !== 3'b010) begin
         n_err++;
         $display("FAIL rstmid_flags cyc=%0d actual=%b required=010", cyc,
                  {RF_WriteEn, LL_Ready, Pipe_Stall});
      end
      tick();
      Rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
         n_vec++;
         if (obs !== exp_vec) begin
            n_err++;
            $display("FAIL rstmid_after cyc=%0d actual=%h required=%h", cyc, obs, exp_vec);
         end
         if (RF_WriteEn !== 1'b0) stale++;
         tick();
      end
      n_vec++;
      if (stale !== 0) begin
         n_err++;
         $display("FAIL rstmid_stale actual=%0d writes required=0", stale);
      end
   endtask

   initial begin
      RegWrite_WB       = 1'b0;
      Write_Register_WB = 5'd0;
      Write_Data_WB     = 32'h0;
      LL_Valid          = 1'b0;
      LL_Register       = 5'd0;
      LL_Data           = 32'h0;
      model_reset();
      test_reset();
      test_idle_slot();
      test_starvation();
      test_full();
      test_zero();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
